// File: rtl/sqrt_iter_unit.sv
// Restoring integer square root, one root bit per clock.
// A single 16-bit CLA performs every trial subtraction.
module cla_16 (
    input  logic [15:0] A_i,
    input  logic [15:0] B_i,
    input  logic        Ci_i,
    output logic [15:0] S_o,
    output logic        Co_o
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [3:0]  w_gp;
    logic [3:0]  w_gg;
    logic [4:0]  w_gc;
    logic [15:0] w_c;

    assign w_p = A_i ^ B_i;
    assign w_g = A_i & B_i;

    always_comb begin
        w_gp = '0;
        w_gg = '0;
        w_gc = '0;
        w_c  = '0;
        for (int k = 0; k < 4; k++) begin
            w_gp[k] = &w_p[4*k +: 4];
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        end
        w_gc[0] = Ci_i;
        for (int k = 0; k < 4; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end
        // Carries inside each 4-bit group come from the group carry-in.
        for (int k = 0; k < 4; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end
    end

    assign S_o  = w_p ^ w_c;
    assign Co_o = w_gc[4];
endmodule

module sqrt_iter_unit #(
    parameter int DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     radicand_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W/2-1:0]   root_o,
    output logic [DATA_W/2:0]     rem_o
);
    localparam int ROOT_W = DATA_W / 2;
    localparam int REM_W  = ROOT_W + 1;
    localparam int CNT_W  = $clog2(ROOT_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_rad;
    logic [REM_W-1:0]    r_rem;
    logic [ROOT_W-1:0]   r_root;
    logic [CNT_W-1:0]    r_cnt;
    logic [ROOT_W-1:0]   r_root_o;
    logic [REM_W-1:0]    r_rem_o;

    logic [REM_W+1:0]    w_shifted;
    logic [ROOT_W+1:0]   w_trial;
    logic [15:0]         w_diff;
    logic                w_fits;
    logic [REM_W-1:0]    w_rem_nxt;
    logic [ROOT_W-1:0]   w_root_nxt;
    logic                w_last;

    assign w_shifted = {r_rem, r_rad[DATA_W-1 -: 2]};
    assign w_trial   = {r_root, 2'b01};

    cla_16 u_cla (
        .A_i  (16'(w_shifted)),
        .B_i  (~16'(w_trial)),
        .Ci_i (1'b1),
        .S_o  (w_diff),
        .Co_o ()
    );

    // Both operands stay below 2^15, so bit 15 is the borrow.
    assign w_fits     = ~w_diff[15];
    assign w_rem_nxt  = w_fits ? w_diff[REM_W-1:0] : w_shifted[REM_W-1:0];
    assign w_root_nxt = {r_root[ROOT_W-2:0], w_fits};
    assign w_last     = (r_cnt == CNT_W'(ROOT_W - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rad    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_cnt    <= '0;
            r_root_o <= '0;
            r_rem_o  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_rad  <= radicand_i;
                        r_rem  <= '0;
                        r_root <= '0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_root_o <= w_root_nxt;
                        r_rem_o  <= w_rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign root_o = r_root_o;
    assign rem_o  = r_rem_o;
endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Directed bench for sqrt_iter_unit: vector table plus
// backpressure, ignored-input and mid-run reset sequences.
module tb_sqrt_iter_unit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] radicand;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  root;
    logic [8:0]  rem;

    int total = 0;
    int bad   = 0;

    sqrt_iter_unit #(.DATA_W(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .radicand_i  (radicand),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .root_o      (root),
        .rem_o       (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rad;
        int          root;
        int          rem;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid after the accept edge; returns edges taken.
    task automatic wait_done(input string nm, output int lat);
        logic rdy_seen;
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        chk({nm, " latency"}, lat, 8);
        chk({nm, " ready_in_run"}, {31'd0, rdy_seen}, 0);
        chk({nm, " ready_in_done"}, {31'd0, in_ready}, 0);
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " valid_drop"}, {31'd0, out_valid}, 0);
        chk({nm, " idle_ready"}, {31'd0, in_ready}, 1);
    endtask

    task automatic run_vec(input logic [15:0] r, input int er,
                           input int em, input string nm);
        int lat;
        chk({nm, " ready_pre"}, {31'd0, in_ready}, 1);
        in_valid = 1'b1;
        radicand = r;
        tick();
        in_valid = 1'b0;
        radicand = '0;
        wait_done(nm, lat);
        chk({nm, " root"}, {24'd0, root}, er);
        chk({nm, " rem"}, {23'd0, rem}, em);
        handshake(nm);
    endtask

    initial begin
        int lat;
        vecs[0] = '{16'd0,     0,   0};
        vecs[1] = '{16'hFFFF,  255, 510};
        vecs[2] = '{16'd144,   12,  0};
        vecs[3] = '{16'd2,     1,   1};
        vecs[4] = '{16'd50000, 223, 271};
        vecs[5] = '{16'd1,     1,   0};
        vecs[6] = '{16'd3,     1,   2};
        vecs[7] = '{16'd255,   15,  30};
        vecs[8] = '{16'd65025, 255, 0};
        vecs[9] = '{16'd65024, 254, 508};

        rst_n = 1'b0;
        in_valid = 1'b1;
        radicand = 16'd77;
        out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk("rst ready", {31'd0, in_ready}, 1);
        chk("rst valid", {31'd0, out_valid}, 0);
        chk("rst root", {24'd0, root}, 0);
        chk("rst rem", {23'd0, rem}, 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i].rad, vecs[i].root, vecs[i].rem,
                    $sformatf("vec%0d", i));
        end

        // Backpressure in DONE with a new operand waiting.
        in_valid = 1'b1;
        radicand = 16'd1000;
        tick();
        in_valid = 1'b0;
        wait_done("bp", lat);
        in_valid = 1'b1;
        radicand = 16'd9;
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", {31'd0, out_valid}, 1);
            chk("bp ready", {31'd0, in_ready}, 0);
            chk("bp root", {24'd0, root}, 31);
            chk("bp rem", {23'd0, rem}, 39);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp back_idle", {31'd0, in_ready}, 1);
        chk("bp no_valid", {31'd0, out_valid}, 0);
        tick();
        in_valid = 1'b0;
        radicand = '0;
        chk("bp9 accepted", {31'd0, in_ready}, 0);
        wait_done("bp9", lat);
        chk("bp9 root", {24'd0, root}, 3);
        chk("bp9 rem", {23'd0, rem}, 0);
        handshake("bp9");

        // Input and early out_ready toggled during RUN are ignored.
        in_valid = 1'b1;
        radicand = 16'd81;
        tick();
        radicand = 16'd400;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            out_ready = ~out_ready;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("ign latency", lat, 8);
        chk("ign root", {24'd0, root}, 9);
        chk("ign rem", {23'd0, rem}, 0);
        handshake("ign");

        // Reset in the 4th RUN cycle aborts the computation.
        in_valid = 1'b1;
        radicand = 16'd1000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst ready", {31'd0, in_ready}, 1);
        chk("mrst valid", {31'd0, out_valid}, 0);
        chk("mrst root", {24'd0, root}, 0);
        chk("mrst rem", {23'd0, rem}, 0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) lat++;
            tick();
        end
        chk("mrst no_result", lat, 0);
        run_vec(16'd225, 15, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sqrt_iter_unit.md
Name: sqrt_iter_unit

Overview:
- Multicycle restoring integer square root, one result bit per clock.
- Consumes the team's 16-bit carry-lookahead adder: one CLA instance performs each trial subtraction.
- Sits between the operand source (valid/ready input) and the result consumer (valid/ready output).
- Produces floor(sqrt(radicand)) and the remainder.

Parameters:
- DATA_W, 16, radicand width; must be even and ≤16, the CLA width.
- ROOT_W, DATA_W/2, root width; derived, not overridden.
- REM_W, ROOT_W+1, remainder width; derived.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  synchronous active-low reset.
- in_valid_i  input  1  radicand valid.
- in_ready_o  output  1  unit can accept a radicand.
- radicand_i  input  DATA_W  unsigned radicand.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- root_o  output  ROOT_W  floor(sqrt(radicand)).
- rem_o  output  REM_W  radicand − root².

Behaviour:
- Reset (rst_n_i=0 at an edge):
  - State goes to IDLE.
  - in_ready_o=1 after reset; out_valid_o=0.
  - root_o=0, rem_o=0; internal radicand shift register and counter cleared.
  - Reset mid-operation aborts the computation; no result is produced.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - If in_valid_i=1 at an edge: latch radicand_i, clear the working remainder, root and counter, and go to RUN.
- RUN:
  - in_ready_o=0, out_valid_o=0; in_valid_i is ignored.
  - One iteration per edge:
    - shifted = (rem << 2) | top two unconsumed radicand bits, MSB pair first (11 bits max at DATA_W=16).
    - trial = (root << 2) | 1 (10 bits max).
    - The CLA computes diff: A_i = zero-extended shifted, B_i = ~zero-extended trial, Ci_i = 1.
    - If diff bit 15 = 0 (shifted ≥ trial): rem ← diff[REM_W-1:0], root ← (root<<1)|1.
    - Otherwise: rem ← shifted[REM_W-1:0], root ← root<<1.
  - Only S_o[15] and the low sum bits are used; Co_o is left unconnected.
  - After ROOT_W iterations (counter = ROOT_W−1 at the edge), go to DONE and load root_o/rem_o with the final values in the same edge.
- DONE:
  - out_valid_o=1; root_o and rem_o are held stable.
  - in_ready_o=0.
  - On an edge with out_ready_i=1, go to IDLE and drop out_valid_o.
  - root_o and rem_o keep the last result until the next DONE load.
- Latency:
  - The accept edge is E0; out_valid_o is high after edge E0+ROOT_W (8 cycles at default).
  - Minimum initiation interval is ROOT_W+2 cycles (accept, ROOT_W iterations, output handshake, then back in IDLE).
- Arithmetic:
  - Unsigned only.
  - The remainder never exceeds 2·root, so it always fits REM_W bits.
  - The diff sign bit is valid because both operands are < 2^15.
- Boundaries:
  - in_valid_i held high across DONE→IDLE: a new operand is accepted on the first IDLE edge, not in the DONE handshake cycle.
  - out_ready_i high before out_valid_o has no effect.
  - Radicand 0 and all-ones are legal.

Test Plan:
- Reset, then radicand 0 accepted -> after 8 cycles out_valid_o=1, root_o=0, rem_o=0; in_ready_o=0 throughout RUN/DONE.
- Radicand 0xFFFF -> root_o=255, rem_o=510; radicand 144 -> root_o=12, rem_o=0.
- Radicand 2 -> root_o=1, rem_o=1; radicand 50000 -> root_o=223, rem_o=271; latency exactly 8 cycles from the accept edge for each.
- Backpressure: radicand 1000, out_ready_i held 0 for 5 cycles in DONE -> root_o=31, rem_o=39 stable; out_valid_o stays 1; in_ready_o stays 0; new in_valid_i with 9 is not accepted until after the handshake, then yields root_o=3, rem_o=0.
- in_valid_i toggled with radicand 400 during RUN of radicand 81 -> result root_o=9, rem_o=0; the 400 is ignored.
- rst_n_i=0 for one edge in the 4th RUN cycle -> next cycle IDLE, in_ready_o=1, out_valid_o=0, root_o=0, rem_o=0; a following radicand 225 gives root_o=15, rem_o=0.
